instr_issue_ctrl: RTL and testbench

Instruction issue controller: the initiator side of the processor datapath's register-address/opcode interface. It holds a small loadable program, steps through it, and drives `rx/ry/rz/op/write_en` into the datapath one instruction per cycle. It captures the datapath's registered `result_out` on `result_in` and returns each result tagged with its program address. It sits between the test/host loader and the processor core.

---
 rtl/issue_pkg.sv | 39 +++
 rtl/issue_prog_mem.sv | 34 +++
 rtl/instr_issue_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_instr_issue_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : issue_pkg
// Description : Shared instruction-word layout, HALT encoding and FSM state
//               type for the instruction issue controller.
// Revision    : 1.0 - initial release
//==============================================================================
package issue_pkg;

    localparam int INSTR_W = 17;

    // Instruction word layout: [16] we, [15:12] op, [11:8] rx, [7:4] ry, [3:0] rz
    localparam int WE_BIT = 16;
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RX_HI  = 11;
    localparam int RX_LO  = 8;
    localparam int RY_HI  = 7;
    localparam int RY_LO  = 4;
    localparam int RZ_HI  = 3;
    localparam int RZ_LO  = 0;

    localparam logic [3:0] HALT_OP = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // HALT requires the write enable clear; op F with we set is a normal instruction.
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return (word[OP_HI:OP_LO] == HALT_OP) && !word[WE_BIT];
    endfunction

endpackage : issue_pkg
`default_nettype wire

// File: rtl/issue_prog_mem.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : issue_prog_mem
// Description : Program store, DEPTH x 17 register array with synchronous
//               write and asynchronous read. Contents survive reset.
// Revision    : 1.0 - initial release
//==============================================================================
module issue_prog_mem
    import issue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : issue_prog_mem
`default_nettype wire

// File: rtl/instr_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : instr_issue_ctrl
// Description : Steps through a loadable program, issues one instruction per
//               cycle to the datapath and returns pc-tagged results in order.
// Revision    : 1.0 - initial release
//==============================================================================
module instr_issue_ctrl
    import issue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               hold,
    output logic               busy,
    output logic               done,
    output logic [3:0]         rx,
    output logic [3:0]         ry,
    output logic [3:0]         rz,
    output logic [3:0]         op,
    output logic               write_en,
    input  logic [31:0]        result_in,
    output logic               res_valid,
    output logic [31:0]        res_data,
    output logic [ADDR_W-1:0]  res_pc,
    output logic [ADDR_W:0]    instr_count
);

    localparam logic [ADDR_W-1:0] c_LAST_PC  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_PC_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_CNT_ONE  = (ADDR_W + 1)'(1);

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W:0]      r_count;
    logic [INSTR_W-1:0]   w_word;
    logic                 w_issue;
    logic                 w_start;
    logic                 w_mem_we;

    logic                 r_write_en;
    logic [3:0]           r_op;
    logic [3:0]           r_rx;
    logic [3:0]           r_ry;
    logic [3:0]           r_rz;

    // Tag pipeline: stage 1 aligns with the issue outputs, stage 2 with result_in.
    logic                 r_v1;
    logic [ADDR_W-1:0]    r_pc1;
    logic                 r_v2;
    logic [ADDR_W-1:0]    r_pc2;

    logic                 r_res_valid;
    logic [31:0]          r_res_data;
    logic [ADDR_W-1:0]    r_res_pc;

    assign w_start  = (r_state == IDLE) && start;
    assign w_mem_we = (r_state == IDLE) && prog_we;

    issue_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (r_pc),
        .rdata (w_word)
    );

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (is_halt(w_word)) begin
                        w_next_state = DRAIN;
                    end else begin
                        w_issue = 1'b1;
                        if (r_pc == c_LAST_PC) begin
                            w_next_state = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                // Both tag stages empty means the last result is on res_* now.
                if (!r_v1 && !r_v2) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Program counter and issue counter
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (w_start) begin
            r_pc <= '0;
        end else if (w_issue && (r_pc != c_LAST_PC)) begin
            r_pc <= r_pc + c_PC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_start) begin
            r_count <= '0;
        end else if (w_issue) begin
            r_count <= r_count + c_CNT_ONE;
        end
    end

    //--------------------------------------------------------------------------
    // Issue registers: zero whenever the cycle carries no instruction
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_en <= 1'b0;
            r_op       <= '0;
            r_rx       <= '0;
            r_ry       <= '0;
            r_rz       <= '0;
        end else if (w_issue) begin
            r_write_en <= w_word[WE_BIT];
            r_op       <= w_word[OP_HI:OP_LO];
            r_rx       <= w_word[RX_HI:RX_LO];
            r_ry       <= w_word[RY_HI:RY_LO];
            r_rz       <= w_word[RZ_HI:RZ_LO];
        end else begin
            r_write_en <= 1'b0;
            r_op       <= '0;
            r_rx       <= '0;
            r_ry       <= '0;
            r_rz       <= '0;
        end
    end

    //--------------------------------------------------------------------------
    // Result tag pipeline and capture
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_pc1 <= '0;
            r_v2  <= 1'b0;
            r_pc2 <= '0;
        end else begin
            r_v1  <= w_issue;
            r_pc1 <= w_issue ? r_pc : '0;
            r_v2  <= r_v1;
            r_pc2 <= r_pc1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_pc    <= '0;
        end else begin
            r_res_valid <= r_v2;
            r_res_data  <= r_v2 ? result_in : '0;
            r_res_pc    <= r_v2 ? r_pc2 : '0;
        end
    end

    assign busy        = (r_state == RUN) || (r_state == DRAIN);
    assign done        = (r_state == DONE);
    assign write_en    = r_write_en;
    assign op          = r_op;
    assign rx          = r_rx;
    assign ry          = r_ry;
    assign rz          = r_rz;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_pc      = r_res_pc;
    assign instr_count = r_count;

endmodule : instr_issue_ctrl
`default_nettype wire

// File: tb/tb_instr_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_instr_issue_ctrl
// Description : Scoreboard bench for instr_issue_ctrl with a per-cycle
//               expected trace built from the program model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_instr_issue_ctrl;

    localparam logic [16:0] c_HALT = 17'h0F000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [16:0] prog_data;
    logic        start;
    logic        hold;
    logic        busy;
    logic        done;
    logic [3:0]  rx, ry, rz, op;
    logic        write_en;
    logic [31:0] result_in;
    logic        res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_pc;
    logic [4:0]  instr_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [16:0] m_mem [16];
    logic        ev [64];
    logic [16:0] ew [64];
    logic [3:0]  ep [64];
    logic [4:0]  ec [64];
    int          done_t;
    logic [35:0] sb_q [$];

    always #5 clk = ~clk;

    instr_issue_ctrl #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .hold        (hold),
        .busy        (busy),
        .done        (done),
        .rx          (rx),
        .ry          (ry),
        .rz          (rz),
        .op          (op),
        .write_en    (write_en),
        .result_in   (result_in),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_pc      (res_pc),
        .instr_count (instr_count)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_word(input int addr, input logic [16:0] data);
        @(posedge clk); #1;
        prog_we   = 1'b1;
        prog_addr = 4'(addr);
        prog_data = data;
        m_mem[addr] = data;
        @(posedge clk); #1;
        prog_we   = 1'b0;
    endtask

    // Offsets are relative to the start cycle S (t = 0).
    task automatic build_trace(input logic [63:0] hmask);
        int  pc;
        int  c;
        int  det;
        int  last_vis;
        bit  fin;
        logic [4:0] cnt;
        for (int t = 0; t < 64; t++) begin
            ev[t] = 1'b0;
            ew[t] = '0;
            ep[t] = '0;
        end
        pc = 0; c = 1; det = 1; last_vis = -10; fin = 0;
        while (!fin && c < 60) begin
            if (hmask[c]) begin
                c++;
            end else begin
                if (m_mem[pc][15:12] == 4'hF && !m_mem[pc][16]) begin
                    det = c;
                    fin = 1;
                end else begin
                    ev[c+1]  = 1'b1;
                    ew[c+1]  = m_mem[pc];
                    ep[c+1]  = 4'(pc);
                    last_vis = c + 1;
                    if (pc == 15) begin
                        det = c;
                        fin = 1;
                    end else begin
                        pc++;
                    end
                end
                c++;
            end
        end
        done_t = (det + 2 > last_vis + 3) ? det + 2 : last_vis + 3;
        cnt = '0;
        for (int t = 0; t < 64; t++) begin
            if (ev[t]) cnt = cnt + 5'd1;
            ec[t] = cnt;
        end
    endtask

    // Starts a run, drives result_in as A0+pc of the prior cycle's issue and
    // checks every cycle through the first idle cycle after done.
    task automatic run_program(input logic [63:0] hmask, input int inj_t, output int obs_done);
        logic [16:0] exp_iss;
        logic        exp_b, exp_d, exp_rv;
        logic [35:0] exp_r;
        build_trace(hmask);
        sb_q.delete();
        obs_done = -1;
        for (int t = 0; t <= done_t + 1; t++) begin
            @(posedge clk); #1;
            start     = (t == 0) || (inj_t >= 0 && (t == inj_t || t == done_t));
            prog_we   = (inj_t >= 0) && (t == inj_t || t == done_t);
            prog_addr = 4'd0;
            prog_data = 17'h1FFFF;
            hold      = hmask[t];
            if (t >= 1 && ev[t-1]) begin
                result_in = 32'hA0 + {28'd0, ep[t-1]};
                sb_q.push_back({ep[t-1], result_in});
            end else begin
                result_in = 32'hDEAD_0000 + t;
            end
            @(negedge clk);
            exp_iss = ev[t] ? ew[t] : 17'd0;
            vec_cnt++;
            if ({write_en, op, rx, ry, rz} !== exp_iss) begin
                err_cnt++;
                $display("FAIL issue t=%0d got %h exp %h", t, {write_en, op, rx, ry, rz}, exp_iss);
            end
            exp_b = (t >= 1) && (t < done_t);
            vec_cnt++;
            if (busy !== exp_b) begin
                err_cnt++;
                $display("FAIL busy t=%0d got %b exp %b", t, busy, exp_b);
            end
            exp_d = (t == done_t);
            vec_cnt++;
            if (done !== exp_d) begin
                err_cnt++;
                $display("FAIL done t=%0d got %b exp %b", t, done, exp_d);
            end
            if (done === 1'b1 && obs_done < 0) obs_done = t;
            exp_rv = (t >= 2) && ev[t-2];
            vec_cnt++;
            if (res_valid !== exp_rv) begin
                err_cnt++;
                $display("FAIL res_valid t=%0d got %b exp %b", t, res_valid, exp_rv);
            end
            if (res_valid === 1'b1) begin
                vec_cnt++;
                if (sb_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL res_extra t=%0d got pc=%h data=%h exp none", t, res_pc, res_data);
                end else begin
                    exp_r = sb_q.pop_front();
                    if ({res_pc, res_data} !== exp_r) begin
                        err_cnt++;
                        $display("FAIL result t=%0d got pc=%h data=%h exp pc=%h data=%h",
                                 t, res_pc, res_data, exp_r[35:32], exp_r[31:0]);
                    end
                end
            end
            if (t >= 1) begin
                vec_cnt++;
                if (instr_count !== ec[t]) begin
                    err_cnt++;
                    $display("FAIL instr_count t=%0d got %0d exp %0d", t, instr_count, ec[t]);
                end
            end
        end
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        hold    = 1'b0;
        result_in = '0;
        vec_cnt++;
        if (sb_q.size() != 0) begin
            err_cnt++;
            $display("FAIL res_missing got %0d outstanding exp 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; hold = 1'b0; result_in = '0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({busy, done, write_en, op, rx, ry, rz, res_valid, res_pc, res_data, instr_count} !== '0) begin
            err_cnt++;
            $display("FAIL reset_init got busy=%b done=%b cnt=%0d exp all zero", busy, done, instr_count);
        end
        rst_n = 1'b1;
        load_word(0, 17'h13123);
        load_word(1, 17'h05A5B);
        load_word(2, 17'h1F0E1);
        load_word(3, c_HALT);
        // Abort a run in S+3 with a mid-cycle reset.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_abort_busy got %b exp 1", busy);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({busy, done, write_en, op, rx, ry, rz, res_valid, res_pc, res_data, instr_count} !== '0) begin
            err_cnt++;
            $display("FAIL reset_async got busy=%b iss=%h cnt=%0d exp all zero",
                     busy, {write_en, op, rx, ry, rz}, instr_count);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL abort_done got done=%b busy=%b exp 0 0", done, busy);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_three_instr();
        int od;
        run_program(64'd0, -1, od);
        vec_cnt++;
        if (od !== 7) begin
            err_cnt++;
            $display("FAIL three_done got %0d exp 7", od);
        end
        vec_cnt++;
        if (instr_count !== 5'd3) begin
            err_cnt++;
            $display("FAIL three_count got %0d exp 3", instr_count);
        end
    endtask

    task automatic test_halt_at_zero();
        int od;
        load_word(0, c_HALT);
        run_program(64'd0, -1, od);
        vec_cnt++;
        if (od !== 3) begin
            err_cnt++;
            $display("FAIL halt0_done got %0d exp 3", od);
        end
        vec_cnt++;
        if (instr_count !== 5'd0) begin
            err_cnt++;
            $display("FAIL halt0_count got %0d exp 0", instr_count);
        end
    endtask

    task automatic test_full_depth();
        int od;
        logic [16:0] w;
        for (int i = 0; i < 16; i++) begin
            w = {i[0], 4'(i % 15), 4'(i), 4'(15 - i), 4'(i ^ 5)};
            load_word(i, w);
        end
        run_program(64'd0, -1, od);
        vec_cnt++;
        if (od !== 20) begin
            err_cnt++;
            $display("FAIL full_done got %0d exp 20", od);
        end
        vec_cnt++;
        if (instr_count !== 5'd16) begin
            err_cnt++;
            $display("FAIL full_count got %0d exp 16", instr_count);
        end
    endtask

    task automatic test_hold();
        int od;
        logic [16:0] w;
        for (int i = 0; i < 5; i++) begin
            w = {1'b1, 4'(i + 1), 4'(i), 4'(2 * i), 4'(3 * i)};
            load_word(i, w);
        end
        load_word(5, c_HALT);
        // Second issue is visible in S+3; hold in S+3 and S+4.
        run_program((64'd1 << 3) | (64'd1 << 4), -1, od);
        vec_cnt++;
        if (od !== 11) begin
            err_cnt++;
            $display("FAIL hold_done got %0d exp 11", od);
        end
        vec_cnt++;
        if (instr_count !== 5'd5) begin
            err_cnt++;
            $display("FAIL hold_count got %0d exp 5", instr_count);
        end
    endtask

    task automatic test_ignored_inputs();
        int od;
        run_program(64'd0, 3, od);
        vec_cnt++;
        if (od !== 9) begin
            err_cnt++;
            $display("FAIL ignored_done got %0d exp 9", od);
        end
        // Re-run unchanged: a stray write to address 0 would alter the issue trace.
        run_program(64'd0, -1, od);
        vec_cnt++;
        if (od !== 9 || instr_count !== 5'd5) begin
            err_cnt++;
            $display("FAIL ignored_rerun got done=%0d cnt=%0d exp 9 5", od, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_three_instr();
        test_halt_at_zero();
        test_full_depth();
        test_hold();
        test_ignored_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_instr_issue_ctrl
`default_nettype wire
